alu_arbiter: RTL and testbench

- Shares one 32-bit combinational ALU (4-bit op select, operands a/b, result c) between two requesters.
- Round-robin arbitration; each request is accepted with a valid/ready handshake.
- The controller registers the operands and op select into the ALU, captures the ALU result, and returns it with a requester ID over a valid/ready response channel.
- Keeps a per-requester count of completed operations.

---
 rtl/alu_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each op is registered into the ALU, its result captured a cycle later and returned over a valid/ready response.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_id,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t            r_state;
  logic              r_ptr;
  logic              r_id;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [3:0]        r_alu_sel;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_id;
  logic              r_res_valid;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;

  // A lone requester always wins; the pointer only breaks ties.
  assign w_idle   = (r_state == IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
  assign w_grant1 = req1_valid & (~req0_valid | r_ptr);

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign busy       = ~w_idle;

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_valid = r_res_valid;
  assign cnt0      = r_cnt0;
  assign cnt1      = r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 4'b0000;
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
      r_res_valid <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0) begin
            r_alu_sel <= req0_sel;
            r_alu_a   <= req0_a;
            r_alu_b   <= req0_b;
            r_id      <= 1'b0;
            r_ptr     <= 1'b1;
            r_state   <= EXEC;
          end else if (w_grant1) begin
            r_alu_sel <= req1_sel;
            r_alu_a   <= req1_a;
            r_alu_b   <= req1_b;
            r_id      <= 1'b1;
            r_ptr     <= 1'b0;
            r_state   <= EXEC;
          end
        end
        // ALU output has had a full cycle to settle from the registered operands.
        EXEC: begin
          r_res_data  <= alu_c;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (r_res_id) r_cnt1 <= r_cnt1 + CNT_ONE;
            else          r_cnt0 <= r_cnt0 + CNT_ONE;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: provides the shared ALU, drives random and directed requests,
// and scores responses, handshakes and counters against a queue-based model.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [3:0]    req0_sel, req1_sel;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0] alu_a, alu_b, alu_c;
  logic [3:0]    alu_sel;
  logic          res_valid, res_ready, res_id, busy;
  logic [DW-1:0] res_data;
  logic [CW-1:0] cnt0, cnt1;

  alu_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [3:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (s)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a ^ b;
      4'd3:    return ~a;
      4'd4:    return a + b;
      4'd5:    return a - b;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return a * b;
      4'd9:    return ~(a & b);
      4'd10:   return a + 32'd1;
      4'd11:   return a - 32'd1;
      4'd12:   return b;
      4'd13:   return {a[15:0], a[31:16]};
      default: return a;
    endcase
  endfunction

  assign alu_c = alu_f(alu_sel, alu_a, alu_b);

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic [3:0]    sel;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            acc;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            vec = 0;
  int            err = 0;
  logic          m_ptr;
  logic [CW-1:0] m_cnt0, m_cnt1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT state with the head of the expected-response queue every cycle.
  task automatic monitor();
    exp_t h;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        q.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        continue;
      end
      chk("busy", busy, q.size() != 0);
      chk("cnt0", cnt0, m_cnt0);
      chk("cnt1", cnt1, m_cnt1);
      if (q.size() == 0) begin
        chk("res_valid_empty", res_valid, 0);
      end else begin
        h = q[0];
        chk("alu_sel", alu_sel, h.sel);
        chk("alu_a", alu_a, h.a);
        chk("alu_b", alu_b, h.b);
        chk("res_valid", res_valid, (cyc - h.acc) >= 1);
        if (res_valid) begin
          chk("res_data", res_data, h.data);
          chk("res_id", res_id, h.id);
          if (res_ready) begin
            void'(q.pop_front());
            if (h.id) m_cnt1 = m_cnt1 + 1'b1;
            else      m_cnt0 = m_cnt0 + 1'b1;
          end
        end
      end
    end
  endtask

  // Drives one cycle; g returns 0 (no accept), 1 (req0) or 2 (req1) per the model.
  task automatic drive(input logic v0, input logic [3:0] s0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                       input logic v1, input logic [3:0] s1, input logic [DW-1:0] a1, input logic [DW-1:0] b1,
                       input logic rr, output int g);
    logic free, e0, e1;
    exp_t e;
    @(negedge clk);
    req0_valid = v0; req0_sel = s0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_sel = s1; req1_a = a1; req1_b = b1;
    res_ready  = rr;
    #1;
    free = (q.size() == 0);
    e0 = free && v0 && (!v1 || m_ptr == 1'b0);
    e1 = free && v1 && (!v0 || m_ptr == 1'b1);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    @(posedge clk);
    #1;
    g = 0;
    if (e0) begin
      e.id = 1'b0; e.data = alu_f(s0, a0, b0); e.sel = s0; e.a = a0; e.b = b0; e.acc = cyc;
      q.push_back(e);
      m_ptr = 1'b1;
      g = 1;
    end else if (e1) begin
      e.id = 1'b1; e.data = alu_f(s1, a1, b1); e.sel = s1; e.a = a1; e.b = b1; e.acc = cyc;
      q.push_back(e);
      m_ptr = 1'b0;
      g = 2;
    end
  endtask

  task automatic idle(input logic rr, input int n);
    int g;
    for (int i = 0; i < n; i++) drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, rr, g);
  endtask

  task automatic rnd(input logic v0, input logic v1, input logic rr, output int g);
    drive(v0, 4'($urandom_range(0, 15)), $urandom, $urandom,
          v1, 4'($urandom_range(0, 15)), $urandom, $urandom, rr, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_ptr = 1'b0;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int g, prev, n;
    rst_n = 1'b1;
    m_ptr = 1'b0;
    m_cnt0 = '0; m_cnt1 = '0;
    req0_valid = 0; req0_sel = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_sel = 0; req1_a = 0; req1_b = 0;
    res_ready = 0;
    fork
      monitor();
    join_none
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single req0 add: 5 + 3.
    drive(1, 4'b0100, 5, 3, 0, 4'd0, 0, 0, 1, g);
    chk("t1_grant", g, 1);
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, g);
    chk("t1_valid", res_valid, 1);
    chk("t1_data", res_data, 8);
    chk("t1_id", res_id, 0);
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, g);
    chk("t1_cnt0", cnt0, 1);
    chk("t1_done", res_valid, 0);

    // Both valid from reset: req0 first, then req1.
    do_reset();
    drive(1, 4'b0101, 10, 4, 1, 4'b0000, 32'hF0, 32'h3C, 1, g);
    chk("t2_first", g, 1);
    drive(0, 4'd0, 0, 0, 1, 4'b0000, 32'hF0, 32'h3C, 1, g);
    chk("t2_data0", res_data, 6);
    chk("t2_id0", res_id, 0);
    drive(0, 4'd0, 0, 0, 1, 4'b0000, 32'hF0, 32'h3C, 1, g);
    drive(0, 4'd0, 0, 0, 1, 4'b0000, 32'hF0, 32'h3C, 1, g);
    chk("t2_second", g, 2);
    drive(0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 1, g);
    chk("t2_data1", res_data, 32'h30);
    chk("t2_id1", res_id, 1);
    idle(1, 1);
    chk("t2_cnt0", cnt0, 1);
    chk("t2_cnt1", cnt1, 1);

    // Continuous contention: grants must alternate.
    prev = 0; n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      rnd(1, 1, 1, g);
      if (g != 0) begin
        if (prev != 0) chk("t3_alternate", g != prev, 1);
        prev = g;
        n++;
      end
    end
    chk("t3_ops", n, 6);
    idle(1, 3);

    // Consumer stalls for 10+ cycles in DONE.
    drive(1, 4'd13, 32'h12345678, 0, 0, 4'd0, 0, 0, 0, g);
    for (int i = 0; i < 11; i++) begin
      rnd(1, 1, 0, g);
      chk("t4_no_accept", g, 0);
    end
    chk("t4_busy", busy, 1);
    chk("t4_data", res_data, 32'h56781234);
    idle(1, 3);

    // Reset pulse while an op is in EXEC.
    drive(0, 4'd0, 0, 0, 1, 4'd15, 32'hDEAD, 32'hBEEF, 1, g);
    chk("t5_accept", g, 2);
    rst_n = 1'b0;
    m_ptr = 1'b0;
    req1_valid = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_a", alu_a, 0);
    chk("t5_alu_sel", alu_sel, 0);
    chk("t5_cnt1", cnt1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 3);
    chk("t5_no_result", res_valid, 0);
    chk("t5_cnt1_after", cnt1, 0);

    // Random traffic, including every op code and consumer back-pressure.
    for (int i = 0; i < 400; i++)
      rnd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), g);
    idle(1, 4);

    // Counter wrap: two req0 ops, then 2^CW req1 ops.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rnd(1, 0, 1, g);
      idle(1, 2);
    end
    n = 0;
    for (int i = 0; i < 4 * (1 << CW) && n < (1 << CW); i++) begin
      rnd(0, 1, 1, g);
      if (g == 2) n++;
    end
    idle(1, 3);
    chk("t6_ops", n, 1 << CW);
    chk("t6_cnt1_wrap", cnt1, 0);
    chk("t6_cnt0", cnt0, 2);

    n = 0;
    while (q.size() != 0 && n < 20) begin
      idle(1, 1);
      n++;
    end
    chk("drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
